dot_seq_ctrl: RTL and testbench

- Sequences one mac_unit (Q4.12 × Q4.12 → Q8.24, 2-register latency) through a length-N dot product for one neuron.
- Fetches weight/feature pairs from two synchronous-read memories and accumulates the products in a wide accumulator.
- Adds a bias, rescales the sum to Q4.12 with saturation and optional ReLU, then presents the result on a valid/ready output.
- Sits between the layer scheduler (start/config) and the activation buffer (output handshake).

---
 rtl/dot_seq_ctrl_pkg.sv | 29 ++
 rtl/dot_seq_ctrl_if.sv | 45 ++++
 rtl/mac_unit.sv | 30 +++
 rtl/dot_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_dot_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dot_seq_ctrl_pkg : shared types and Q4.12 constants for the dot sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dot_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_FINISH = 3'd3,
    S_OUT    = 3'd4
  } state_e;

  localparam int          Q_FRAC  = 12;
  localparam logic [15:0] Q_MAX   = 16'h7FFF;
  localparam logic [15:0] Q_MIN   = 16'h8000;
  localparam int          MAC_LAT = 2;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
  } q_res_t;

endpackage

`default_nettype wire

// File: rtl/dot_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// dot_seq_ctrl_if : config, memory-read and result handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dot_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] cfg_base_w;
  logic [ADDR_W-1:0] cfg_base_x;
  logic              cfg_relu;
  logic [15:0]       bias;
  logic              busy;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [15:0]       w_rd_data;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [15:0]       x_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              out_sat;

  modport master (
    input  start, cfg_len, cfg_base_w, cfg_base_x, cfg_relu, bias,
    input  w_rd_data, x_rd_data, out_ready,
    output busy, w_rd_en, w_rd_addr, x_rd_en, x_rd_addr,
    output out_valid, out_data, out_sat
  );

  modport slave (
    output start, cfg_len, cfg_base_w, cfg_base_x, cfg_relu, bias,
    output w_rd_data, x_rd_data, out_ready,
    input  busy, w_rd_en, w_rd_addr, x_rd_en, x_rd_addr,
    input  out_valid, out_data, out_sat
  );

endinterface

`default_nettype wire

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit : Q4.12 x Q4.12 -> Q8.24 signed multiplier, two register stages
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_unit (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic signed [15:0] weight_i,
  input  logic signed [15:0] data_in_i,
  output logic signed [31:0] product_o
);

  logic signed [31:0] mul_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_q     <= '0;
      product_o <= '0;
    end else if (en_i) begin
      mul_q     <= 32'(weight_i) * 32'(data_in_i);
      product_o <= mul_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dot_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dot_seq_ctrl : length-N dot product + bias, Q4.12 saturate/ReLU, valid/ready
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dot_seq_ctrl
  import dot_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int ACC_W  = 42,
  parameter int FRAC   = Q_FRAC
) (
  input  logic           clk,
  input  logic           rst,
  dot_seq_ctrl_if.master bus
);

  localparam int DRAIN_CYC = MAC_LAT + 1;
  localparam logic signed [ACC_W-FRAC-1:0] R_MAX = {{(ACC_W-FRAC-16){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-FRAC-1:0] R_MIN = {{(ACC_W-FRAC-16){1'b1}}, Q_MIN};

  state_e                    state_q;
  logic [LEN_W-1:0]          rem_q;
  logic [1:0]                drain_q;
  logic [MAC_LAT:0]          vld_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      rd_en_q;
  logic [ADDR_W-1:0]         w_addr_q;
  logic [ADDR_W-1:0]         x_addr_q;
  logic                      relu_q;
  logic [15:0]               bias_q;
  logic                      out_valid_q;
  logic [15:0]               out_data_q;
  logic                      out_sat_q;

  logic                      w_mac_en;
  logic signed [31:0]        w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_sum;
  q_res_t                    w_res;

  function automatic q_res_t sat_relu(input logic signed [ACC_W-1:0] sum, input logic relu);
    logic signed [ACC_W-FRAC-1:0] r;
    q_res_t res;
    r = sum[ACC_W-1:FRAC];
    if (r > R_MAX) begin
      res.data = Q_MAX;
      res.sat  = 1'b1;
    end else if (r < R_MIN) begin
      res.data = Q_MIN;
      res.sat  = 1'b1;
    end else begin
      res.data = r[15:0];
      res.sat  = 1'b0;
    end
    // ReLU clamps the value only; the saturation flag survives
    if (relu && res.data[15]) res.data = 16'h0000;
    return res;
  endfunction

  assign w_mac_en   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
  assign w_sum      = acc_q + ({{(ACC_W-16){bias_q[15]}}, bias_q} <<< FRAC);
  assign w_res      = sat_relu(w_sum, relu_q);

  mac_unit u_mac (
    .clk       (clk),
    .rst_n     (!rst),
    .en_i      (w_mac_en),
    .weight_i  (bus.w_rd_data),
    .data_in_i (bus.x_rd_data),
    .product_o (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      drain_q     <= '0;
      vld_q       <= '0;
      acc_q       <= '0;
      rd_en_q     <= 1'b0;
      w_addr_q    <= '0;
      x_addr_q    <= '0;
      relu_q      <= 1'b0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // Valid bits track each issued pair through memory + both MAC stages
      if (w_mac_en) begin
        vld_q <= {vld_q[MAC_LAT-1:0], rd_en_q};
        if (vld_q[MAC_LAT]) acc_q <= acc_q + w_prod_ext;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            relu_q   <= bus.cfg_relu;
            bias_q   <= bus.bias;
            acc_q    <= '0;
            vld_q    <= '0;
            w_addr_q <= bus.cfg_base_w;
            x_addr_q <= bus.cfg_base_x;
            if (bus.cfg_len == '0) begin
              state_q <= S_FINISH;
            end else begin
              state_q <= S_ISSUE;
              rd_en_q <= 1'b1;
              rem_q   <= bus.cfg_len - 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (rem_q == '0) begin
            rd_en_q <= 1'b0;
            drain_q <= 2'(DRAIN_CYC - 1);
            state_q <= S_DRAIN;
          end else begin
            rem_q    <= rem_q - 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
            x_addr_q <= x_addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) state_q <= S_FINISH;
          else               drain_q <= drain_q - 1'b1;
        end
        S_FINISH: begin
          out_data_q  <= w_res.data;
          out_sat_q   <= w_res.sat;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.w_rd_en   = rd_en_q;
  assign bus.x_rd_en   = rd_en_q;
  assign bus.w_rd_addr = w_addr_q;
  assign bus.x_rd_addr = x_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dot_seq_ctrl : directed and randomized checks of dot_seq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dot_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_seq_ctrl_if #(.ADDR_W(10), .LEN_W(11)) ifc ();

  dot_seq_ctrl #(.ADDR_W(10), .LEN_W(11), .ACC_W(42), .FRAC(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [15:0] wmem [1024];
  logic [15:0] xmem [1024];
  logic [9:0]  wlog [$];
  logic [9:0]  xlog [$];
  int          hs_cnt;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Synchronous-read memories plus read/handshake monitors
  always @(posedge clk) begin
    if (ifc.w_rd_en) begin
      ifc.w_rd_data <= wmem[ifc.w_rd_addr];
      wlog.push_back(ifc.w_rd_addr);
    end
    if (ifc.x_rd_en) begin
      ifc.x_rd_data <= xmem[ifc.x_rd_addr];
      xlog.push_back(ifc.x_rd_addr);
    end
    if (ifc.out_valid && ifc.out_ready) hs_cnt++;
  end

  logic [15:0] got_data;
  logic        got_sat;
  int          got_lat, w_reads, x_reads, addr_err;
  bit          stable_ok;
  logic        post_valid, post_busy;

  task automatic model(input int len, input int bw, input int bx, input bit relu,
                       input logic [15:0] bias, output logic [15:0] d, output logic s);
    longint acc, r;
    acc = 0;
    for (int i = 0; i < len; i++)
      acc += longint'($signed(wmem[(bw + i) % 1024])) * longint'($signed(xmem[(bx + i) % 1024]));
    acc += longint'($signed(bias)) * 4096;
    r = acc >>> 12;
    if (r > 32767)       begin d = 16'h7FFF; s = 1'b1; end
    else if (r < -32768) begin d = 16'h8000; s = 1'b1; end
    else                 begin d = r[15:0];  s = 1'b0; end
    if (relu && d[15]) d = 16'h0000;
  endtask

  task automatic fill(input int base, input int len, input logic [15:0] v, input bit is_w);
    for (int i = 0; i < len; i++)
      if (is_w) wmem[(base + i) % 1024] = v; else xmem[(base + i) % 1024] = v;
  endtask

  task automatic run_job(input int len, input int bw, input int bx, input bit relu,
                         input logic [15:0] bias, input int hold, input int pulse_at,
                         input bit start_on_hs);
    int k;
    wlog.delete();
    xlog.delete();
    hs_cnt = 0;
    @(negedge clk);
    ifc.start      = 1'b1;
    ifc.cfg_len    = 11'(len);
    ifc.cfg_base_w = 10'(bw);
    ifc.cfg_base_x = 10'(bx);
    ifc.cfg_relu   = relu;
    ifc.bias       = bias;
    @(negedge clk);
    k = 1;
    ifc.start = (pulse_at == 1);
    while (!ifc.out_valid && k < 3000) begin
      @(negedge clk);
      k++;
      ifc.start = (k == pulse_at);
    end
    ifc.start = 1'b0;
    got_lat   = k;
    got_data  = ifc.out_data;
    got_sat   = ifc.out_sat;
    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!ifc.out_valid || ifc.out_data !== got_data || ifc.out_sat !== got_sat) stable_ok = 1'b0;
    end
    ifc.out_ready = 1'b1;
    ifc.start     = start_on_hs;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    ifc.start     = 1'b0;
    post_valid = ifc.out_valid;
    post_busy  = ifc.busy;
    w_reads  = wlog.size();
    x_reads  = xlog.size();
    addr_err = 0;
    foreach (wlog[j]) if (wlog[j] !== 10'((bw + j) % 1024)) addr_err++;
    foreach (xlog[j]) if (xlog[j] !== 10'((bx + j) % 1024)) addr_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({ifc.busy, ifc.w_rd_en, ifc.x_rd_en, ifc.out_valid, ifc.out_sat} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {ifc.busy, ifc.w_rd_en, ifc.x_rd_en, ifc.out_valid, ifc.out_sat});
    else pass_cnt++;
    total_cnt++;
    if ({ifc.out_data, ifc.w_rd_addr, ifc.x_rd_addr} !== 36'h0)
      $display("FAIL reset_data: got %h want 0", {ifc.out_data, ifc.w_rd_addr, ifc.x_rd_addr});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int          t_len [6] = '{3, 4, 4, 4, 5, 5};
    logic [15:0] t_w   [6] = '{16'h1000, 16'h1000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
    bit          t_rl  [6] = '{0, 0, 0, 1, 0, 1};
    logic [15:0] t_d   [6] = '{16'h6000, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h0000};
    logic        t_s   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 6; t++) begin
      fill(100, t_len[t], t_w[t], 1'b1);
      fill(500, t_len[t], 16'h2000, 1'b0);
      run_job(t_len[t], 100, 500, t_rl[t], 16'h0000, 0, 0, 1'b0);
      total_cnt++;
      if ({got_data, got_sat} !== {t_d[t], t_s[t]})
        $display("FAIL directed%0d_result: got %h/%b want %h/%b", t, got_data, got_sat, t_d[t], t_s[t]);
      else pass_cnt++;
      total_cnt++;
      if (got_lat !== t_len[t] + 5)
        $display("FAIL directed%0d_latency: got %0d want %0d", t, got_lat, t_len[t] + 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_len();
    run_job(0, 7, 9, 1'b0, 16'h0800, 0, 0, 1'b0);
    total_cnt++;
    if ({got_data, got_sat} !== {16'h0800, 1'b0})
      $display("FAIL zero_len_result: got %h/%b want 0800/0", got_data, got_sat);
    else pass_cnt++;
    total_cnt++;
    if (got_lat !== 2) $display("FAIL zero_len_latency: got %0d want 2", got_lat);
    else pass_cnt++;
    total_cnt++;
    if (w_reads + x_reads !== 0) $display("FAIL zero_len_reads: got %0d want 0", w_reads + x_reads);
    else pass_cnt++;
  endtask

  task automatic test_wrap_and_ignore_start();
    fill(10'h3FF, 2, 16'h1000, 1'b1);
    fill(10, 2, 16'h2000, 1'b0);
    run_job(2, 10'h3FF, 10, 1'b0, 16'h0000, 0, 2, 1'b0);
    total_cnt++;
    if (w_reads !== 2 || x_reads !== 2)
      $display("FAIL wrap_reads: got %0d/%0d want 2/2", w_reads, x_reads);
    else pass_cnt++;
    total_cnt++;
    if (addr_err !== 0) $display("FAIL wrap_addr: got %0d bad addresses want 0", addr_err);
    else pass_cnt++;
    total_cnt++;
    if (got_data !== 16'h4000) $display("FAIL wrap_result: got %h want 4000", got_data);
    else pass_cnt++;
    total_cnt++;
    if (post_busy !== 1'b0) $display("FAIL wrap_restart: busy got %b want 0", post_busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    fill(200, 3, 16'h1000, 1'b1);
    fill(300, 3, 16'h2000, 1'b0);
    run_job(3, 200, 300, 1'b0, 16'h0000, 10, 0, 1'b1);
    total_cnt++;
    if (stable_ok !== 1'b1) $display("FAIL bp_stable: got %b want 1", stable_ok);
    else pass_cnt++;
    total_cnt++;
    if ({post_valid, post_busy} !== 2'b00)
      $display("FAIL bp_release: valid/busy got %b want 00", {post_valid, post_busy});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (hs_cnt !== 1 || ifc.busy !== 1'b0)
      $display("FAIL bp_single_hs: hs %0d busy %b want 1/0", hs_cnt, ifc.busy);
    else pass_cnt++;
    total_cnt++;
    if (ifc.out_data !== 16'h6000) $display("FAIL bp_hold_data: got %h want 6000", ifc.out_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_job();
    fill(0, 16, 16'h7000, 1'b1);
    fill(0, 16, 16'h7000, 1'b0);
    @(negedge clk);
    ifc.start = 1'b1; ifc.cfg_len = 11'd16; ifc.cfg_base_w = '0; ifc.cfg_base_x = '0;
    ifc.cfg_relu = 1'b0; ifc.bias = 16'h0100;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({ifc.busy, ifc.w_rd_en, ifc.x_rd_en, ifc.out_valid, ifc.out_sat,
         ifc.out_data, ifc.w_rd_addr, ifc.x_rd_addr} !== 41'h0)
      $display("FAIL midreset_outputs: got %h want 0", {ifc.busy, ifc.w_rd_en, ifc.x_rd_en,
               ifc.out_valid, ifc.out_sat, ifc.out_data, ifc.w_rd_addr, ifc.x_rd_addr});
    else pass_cnt++;
    rst = 1'b0;
    fill(40, 3, 16'h1000, 1'b1);
    fill(60, 3, 16'h2000, 1'b0);
    run_job(3, 40, 60, 1'b0, 16'h0000, 0, 0, 1'b0);
    total_cnt++;
    if ({got_data, got_sat} !== {16'h6000, 1'b0})
      $display("FAIL midreset_fresh: got %h/%b want 6000/0", got_data, got_sat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] ed, v;
    logic        es;
    int          len, bw, bx;
    bit          relu;
    logic [15:0] bias;
    for (int it = 0; it < 10; it++) begin
      len  = $urandom_range(0, 40);
      bw   = $urandom_range(0, 1023);
      bx   = $urandom_range(0, 1023);
      relu = 1'($urandom_range(0, 1));
      bias = 16'($urandom);
      for (int i = 0; i < len; i++) begin
        v = 16'($urandom);
        if (it % 2 == 1) v = {{5{v[10]}}, v[10:0]};
        wmem[(bw + i) % 1024] = v;
        v = 16'($urandom);
        if (it % 2 == 1) v = {{5{v[10]}}, v[10:0]};
        xmem[(bx + i) % 1024] = v;
      end
      model(len, bw, bx, relu, bias, ed, es);
      run_job(len, bw, bx, relu, bias, $urandom_range(0, 3), 0, 1'b0);
      total_cnt++;
      if ({got_data, got_sat} !== {ed, es})
        $display("FAIL rand%0d_result: got %h/%b want %h/%b (N=%0d)", it, got_data, got_sat, ed, es, len);
      else pass_cnt++;
      total_cnt++;
      if (got_lat !== ((len == 0) ? 2 : len + 5) || w_reads !== len || addr_err !== 0)
        $display("FAIL rand%0d_timing: lat %0d reads %0d bad %0d want lat %0d reads %0d bad 0",
                 it, got_lat, w_reads, addr_err, (len == 0) ? 2 : len + 5, len);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.start = 1'b0; ifc.cfg_len = '0; ifc.cfg_base_w = '0; ifc.cfg_base_x = '0;
    ifc.cfg_relu = 1'b0; ifc.bias = '0; ifc.out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = '0;
      xmem[i] = '0;
    end
    test_reset();
    test_directed();
    test_zero_len();
    test_wrap_and_ignore_start();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
